// File: rtl/dsp_unit_acc.sv
// dsp_unit_acc: dual-lane packed multiply-accumulate slice.
// Two signed weights share one multiplier by packing the high weight SPLIT
// bits above the low weight. The product can pass straight through, be added
// to a cascade input, or be accumulated over a group of taps. The packed
// result is unpacked into its two lanes at the output.
module dsp_unit_acc #(
    parameter int WL_W  = 8,
    parameter int WH_W  = 8,
    parameter int F_W   = 8,
    parameter int SPLIT = 18,
    parameter int ACC_W = 48
) (
    input  logic                           I_clk,
    input  logic                           I_rst,
    input  logic                           I_valid,
    input  logic [1:0]                     I_mode,
    input  logic [7:0]                     I_taps,
    input  logic signed [WL_W-1:0]         I_weight_l,
    input  logic signed [WH_W-1:0]         I_weight_h,
    input  logic signed [F_W-1:0]          I_feature,
    input  logic [ACC_W-1:0]               I_pcin,
    input  logic                           I_clr,
    output logic                           O_valid,
    output logic                           O_last,
    output logic [ACC_W-1:0]               O_p,
    output logic [ACC_W-1:0]               O_pcout,
    output logic signed [SPLIT-1:0]        O_lo,
    output logic signed [ACC_W-SPLIT-1:0]  O_hi
);

    // Stage 1: raw input registers
    logic                    s1Valid_q, s1Valid_d;
    logic [1:0]              s1Mode_q,  s1Mode_d;
    logic [7:0]              s1Taps_q,  s1Taps_d;
    logic signed [WL_W-1:0]  s1Wl_q,    s1Wl_d;
    logic signed [WH_W-1:0]  s1Wh_q,    s1Wh_d;
    logic signed [F_W-1:0]   s1F_q,     s1F_d;

    // Stage 2: pre-added packed weight and delayed feature
    logic                    s2Valid_q, s2Valid_d;
    logic [1:0]              s2Mode_q,  s2Mode_d;
    logic [7:0]              s2Taps_q,  s2Taps_d;
    logic [ACC_W-1:0]        s2Ad_q,    s2Ad_d;
    logic signed [F_W-1:0]   s2F_q,     s2F_d;

    // M stage: product register
    logic                    mValid_q,  mValid_d;
    logic [1:0]              mMode_q,   mMode_d;
    logic [7:0]              mTaps_q,   mTaps_d;
    logic [ACC_W-1:0]        m_q,       m_d;

    // P stage: result, strobes and group state
    logic [ACC_W-1:0]        p_q,       p_d;
    logic                    oValid_q,  oValid_d;
    logic                    oLast_q,   oLast_d;
    logic [7:0]              tapCnt_q,  tapCnt_d;
    logic [7:0]              tapsLat_q, tapsLat_d;
    logic [ACC_W-1:0]        acc_q,     acc_d;
    logic                    grpSeed_q, grpSeed_d;

    // Datapath helpers
    logic [ACC_W-1:0]        wlExt;
    logic [ACC_W-1:0]        whExt;
    logic signed [ACC_W-1:0] adSigned;
    logic signed [ACC_W-1:0] fExt;
    logic signed [ACC_W-1:0] mProd;
    logic [7:0]              tapsNew;
    logic                    grpOpen;
    logic [ACC_W-1:0]        grpSum;
    logic [7:0]              grpCnt;
    logic [7:0]              grpTaps;

    // Stage 1 next state: capture a beat unless a flush drops it
    always_comb begin
        s1Valid_d = I_valid & ~I_clr;
        s1Mode_d  = s1Mode_q;
        s1Taps_d  = s1Taps_q;
        s1Wl_d    = s1Wl_q;
        s1Wh_d    = s1Wh_q;
        s1F_d     = s1F_q;
        if (I_valid) begin
            s1Mode_d = I_mode;
            s1Taps_d = I_taps;
            s1Wl_d   = I_weight_l;
            s1Wh_d   = I_weight_h;
            s1F_d    = I_feature;
        end
    end

    // Stage 2 next state: pack the two weights into one wide operand
    always_comb begin
        wlExt     = {{(ACC_W-WL_W){s1Wl_q[WL_W-1]}}, s1Wl_q};
        whExt     = {{(ACC_W-WH_W){s1Wh_q[WH_W-1]}}, s1Wh_q};
        s2Valid_d = s1Valid_q & ~I_clr;
        s2Mode_d  = s2Mode_q;
        s2Taps_d  = s2Taps_q;
        s2Ad_d    = s2Ad_q;
        s2F_d     = s2F_q;
        if (s1Valid_q) begin
            s2Mode_d = s1Mode_q;
            s2Taps_d = s1Taps_q;
            s2Ad_d   = (whExt << SPLIT) + wlExt;
            s2F_d    = s1F_q;
        end
    end

    // M stage next state: signed packed product, wrapped to ACC_W bits
    always_comb begin
        adSigned = $signed(s2Ad_q);
        fExt     = {{(ACC_W-F_W){s2F_q[F_W-1]}}, s2F_q};
        mProd    = adSigned * fExt;
        mValid_d = s2Valid_q & ~I_clr;
        mMode_d  = mMode_q;
        mTaps_d  = mTaps_q;
        m_d      = m_q;
        if (s2Valid_q) begin
            mMode_d = s2Mode_q;
            mTaps_d = s2Taps_q;
            m_d     = mProd;
        end
    end

    // P stage next state: pass-through, cascade add, or group accumulation
    always_comb begin
        p_d       = p_q;
        oValid_d  = 1'b0;
        oLast_d   = 1'b0;
        tapCnt_d  = tapCnt_q;
        tapsLat_d = tapsLat_q;
        acc_d     = acc_q;
        grpSeed_d = grpSeed_q;
        tapsNew   = (mTaps_q == 8'd0) ? 8'd1 : mTaps_q;
        grpOpen   = (tapCnt_q != 8'd0) && (grpSeed_q == mMode_q[0]);
        grpSum    = '0;
        grpCnt    = 8'd0;
        grpTaps   = tapsNew;
        if (I_clr) begin
            tapCnt_d = 8'd0;
            acc_d    = '0;
        end else if (mValid_q) begin
            if (!mMode_q[1]) begin
                p_d      = mMode_q[0] ? (m_q + I_pcin) : m_q;
                oValid_d = 1'b1;
                oLast_d  = 1'b1;
                tapCnt_d = 8'd0;
                acc_d    = '0;
            end else begin
                if (grpOpen) begin
                    grpSum  = acc_q + m_q;
                    grpCnt  = tapCnt_q;
                    grpTaps = tapsLat_q;
                end else begin
                    grpSum    = mMode_q[0] ? (m_q + I_pcin) : m_q;
                    grpCnt    = 8'd0;
                    grpTaps   = tapsNew;
                    tapsLat_d = tapsNew;
                    grpSeed_d = mMode_q[0];
                end
                if (grpCnt == grpTaps - 8'd1) begin
                    p_d      = grpSum;
                    oValid_d = 1'b1;
                    oLast_d  = 1'b1;
                    tapCnt_d = 8'd0;
                    acc_d    = '0;
                end else begin
                    acc_d    = grpSum;
                    tapCnt_d = grpCnt + 8'd1;
                end
            end
        end
    end

    // All pipeline and group registers, cleared by the synchronous reset
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            s1Valid_q <= 1'b0;
            s1Mode_q  <= '0;
            s1Taps_q  <= '0;
            s1Wl_q    <= '0;
            s1Wh_q    <= '0;
            s1F_q     <= '0;
            s2Valid_q <= 1'b0;
            s2Mode_q  <= '0;
            s2Taps_q  <= '0;
            s2Ad_q    <= '0;
            s2F_q     <= '0;
            mValid_q  <= 1'b0;
            mMode_q   <= '0;
            mTaps_q   <= '0;
            m_q       <= '0;
            p_q       <= '0;
            oValid_q  <= 1'b0;
            oLast_q   <= 1'b0;
            tapCnt_q  <= '0;
            tapsLat_q <= '0;
            acc_q     <= '0;
            grpSeed_q <= 1'b0;
        end else begin
            s1Valid_q <= s1Valid_d;
            s1Mode_q  <= s1Mode_d;
            s1Taps_q  <= s1Taps_d;
            s1Wl_q    <= s1Wl_d;
            s1Wh_q    <= s1Wh_d;
            s1F_q     <= s1F_d;
            s2Valid_q <= s2Valid_d;
            s2Mode_q  <= s2Mode_d;
            s2Taps_q  <= s2Taps_d;
            s2Ad_q    <= s2Ad_d;
            s2F_q     <= s2F_d;
            mValid_q  <= mValid_d;
            mMode_q   <= mMode_d;
            mTaps_q   <= mTaps_d;
            m_q       <= m_d;
            p_q       <= p_d;
            oValid_q  <= oValid_d;
            oLast_q   <= oLast_d;
            tapCnt_q  <= tapCnt_d;
            tapsLat_q <= tapsLat_d;
            acc_q     <= acc_d;
            grpSeed_q <= grpSeed_d;
        end
    end

    // Unpack the lanes; a negative low lane borrowed one from the high lane
    always_comb begin
        O_valid = oValid_q;
        O_last  = oLast_q;
        O_p     = p_q;
        O_pcout = p_q;
        O_lo    = p_q[SPLIT-1:0];
        O_hi    = p_q[ACC_W-1:SPLIT] + {{(ACC_W-SPLIT-1){1'b0}}, p_q[SPLIT-1]};
    end

endmodule

// File: tb/tb_dsp_unit_acc.sv
// tb_dsp_unit_acc: directed vectors with hand-computed results for dsp_unit_acc,
// followed by multi-cycle sequences for groups, aborts, flush and reset.
module tb_dsp_unit_acc;

    localparam int WL_W  = 8;
    localparam int WH_W  = 8;
    localparam int F_W   = 8;
    localparam int SPLIT = 18;
    localparam int ACC_W = 48;

    logic                          I_clk;
    logic                          I_rst;
    logic                          I_valid;
    logic [1:0]                    I_mode;
    logic [7:0]                    I_taps;
    logic signed [WL_W-1:0]        I_weight_l;
    logic signed [WH_W-1:0]        I_weight_h;
    logic signed [F_W-1:0]         I_feature;
    logic [ACC_W-1:0]              I_pcin;
    logic                          I_clr;
    logic                          O_valid;
    logic                          O_last;
    logic [ACC_W-1:0]              O_p;
    logic [ACC_W-1:0]              O_pcout;
    logic signed [SPLIT-1:0]       O_lo;
    logic signed [ACC_W-SPLIT-1:0] O_hi;

    int checks;
    int errors;
    logic [ACC_W-1:0] heldP;

    typedef struct {
        string             name;
        logic [1:0]        mode;
        logic [7:0]        taps;
        int                wl;
        int                wh;
        int                f;
        logic [ACC_W-1:0]  pcin;
        logic [ACC_W-1:0]  p;
        logic [SPLIT-1:0]  lo;
        logic [ACC_W-SPLIT-1:0] hi;
    } vecT;

    vecT vecs[8];

    dsp_unit_acc #(
        .WL_W(WL_W), .WH_W(WH_W), .F_W(F_W), .SPLIT(SPLIT), .ACC_W(ACC_W)
    ) dut (
        .I_clk(I_clk), .I_rst(I_rst), .I_valid(I_valid), .I_mode(I_mode),
        .I_taps(I_taps), .I_weight_l(I_weight_l), .I_weight_h(I_weight_h),
        .I_feature(I_feature), .I_pcin(I_pcin), .I_clr(I_clr),
        .O_valid(O_valid), .O_last(O_last), .O_p(O_p), .O_pcout(O_pcout),
        .O_lo(O_lo), .O_hi(O_hi)
    );

    // Free-running clock
    initial begin
        I_clk = 1'b0;
        forever #5 I_clk = ~I_clk;
    end

    // Drive one cycle of inputs on the falling edge, return just after the rising edge
    task automatic applyStimulus(input logic v, input logic [1:0] m, input logic [7:0] tp,
                                 input int wl, input int wh, input int f,
                                 input logic [ACC_W-1:0] pc, input logic clr, input logic rst);
        @(negedge I_clk);
        I_valid    = v;
        I_mode     = m;
        I_taps     = tp;
        I_weight_l = wl[WL_W-1:0];
        I_weight_h = wh[WH_W-1:0];
        I_feature  = f[F_W-1:0];
        I_pcin     = pc;
        I_clr      = clr;
        I_rst      = rst;
        @(posedge I_clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 2'b00, 8'd0, 0, 0, 0, I_pcin, 1'b0, 1'b0);
    endtask

    // Compare strobes and result against expectations
    task automatic checkOutput(input string nm, input logic ev, input logic [ACC_W-1:0] ep);
        checks++;
        if (O_valid !== ev || O_last !== ev || O_p !== ep || O_pcout !== ep) begin
            errors++;
            $display("[TB] FAIL %s: got valid=%0b last=%0b p=%0d pcout=%0d, expected valid=%0b last=%0b p=%0d",
                     nm, O_valid, O_last, $signed(O_p), $signed(O_pcout), ev, ev, $signed(ep));
        end
        if (ev) heldP = ep;
    endtask

    task automatic checkLanes(input string nm, input logic [SPLIT-1:0] el,
                              input logic [ACC_W-SPLIT-1:0] eh);
        checks++;
        if (O_lo !== el || O_hi !== eh) begin
            errors++;
            $display("[TB] FAIL %s lanes: got lo=%0d hi=%0d, expected lo=%0d hi=%0d",
                     nm, O_lo, O_hi, $signed(el), $signed(eh));
        end
    endtask

    task automatic expectIdle(input string nm);
        checkOutput(nm, 1'b0, heldP);
    endtask

    task automatic expectOut(input string nm, input logic [ACC_W-1:0] ep);
        checkOutput(nm, 1'b1, ep);
    endtask

    // Main test sequence
    initial begin
        checks = 0;
        errors = 0;
        heldP  = '0;
        I_valid = 1'b0; I_mode = 2'b00; I_taps = 8'd0; I_weight_l = '0;
        I_weight_h = '0; I_feature = '0; I_pcin = '0; I_clr = 1'b0; I_rst = 1'b1;

        vecs[0] = '{"m00_wh_neg", 2'b00, 8'd0, 3, -2, 5, 48'd0,
                    48'(-2621425), 18'd15, 30'(-10)};
        vecs[1] = '{"m00_wl_neg", 2'b00, 8'd0, -3, 2, 5, 48'd0,
                    48'd2621425, 18'(-15), 30'd10};
        vecs[2] = '{"m01_pcin", 2'b01, 8'd0, 2, 0, 3, 48'd100,
                    48'd106, 18'd106, 30'd0};
        vecs[3] = '{"m00_min", 2'b00, 8'd0, -128, -128, -128, 48'd0,
                    48'd4294983680, 18'd16384, 30'd16384};
        vecs[4] = '{"m11_taps0", 2'b11, 8'd0, 1, 0, 4, 48'd10,
                    48'd14, 18'd14, 30'd0};
        vecs[5] = '{"m01_neg_one", 2'b01, 8'd0, 0, 0, 0, 48'hFFFF_FFFF_FFFF,
                    48'hFFFF_FFFF_FFFF, 18'h3FFFF, 30'd0};
        vecs[6] = '{"m00_max", 2'b00, 8'd0, 127, 127, 127, 48'd0,
                    48'd4228136705, 18'd16129, 30'd16129};
        vecs[7] = '{"m01_wrap", 2'b01, 8'd0, 1, 0, 1, 48'h7FFF_FFFF_FFFF,
                    48'h8000_0000_0000, 18'd0, 30'h2000_0000};

        // Reset state
        applyStimulus(1'b0, 2'b00, 8'd0, 0, 0, 0, 48'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 2'b00, 8'd0, 0, 0, 0, 48'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 2'b00, 8'd0, 0, 0, 0, 48'd0, 1'b0, 1'b0);
        expectIdle("reset_state");
        checkLanes("reset_state", 18'd0, 30'd0);

        // Single-beat vectors: result four edges after the beat, then held
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vecs[i].mode, vecs[i].taps, vecs[i].wl, vecs[i].wh,
                          vecs[i].f, vecs[i].pcin, 1'b0, 1'b0);
            idleCycle();
            idleCycle();
            idleCycle();
            expectOut(vecs[i].name, vecs[i].p);
            checkLanes(vecs[i].name, vecs[i].lo, vecs[i].hi);
            idleCycle();
            expectIdle({vecs[i].name, "_hold"});
        end

        // Three-tap group with a two-cycle gap
        I_pcin = 48'd0;
        applyStimulus(1'b1, 2'b10, 8'd3, 1, 0, 1, 48'd0, 1'b0, 1'b0); expectIdle("grp3_c0");
        applyStimulus(1'b1, 2'b10, 8'd3, 1, 0, 2, 48'd0, 1'b0, 1'b0); expectIdle("grp3_c1");
        idleCycle(); expectIdle("grp3_c2");
        idleCycle(); expectIdle("grp3_c3");
        applyStimulus(1'b1, 2'b10, 8'd3, 1, 0, 3, 48'd0, 1'b0, 1'b0); expectIdle("grp3_c4");
        idleCycle(); expectIdle("grp3_c5");
        idleCycle(); expectIdle("grp3_c6");
        idleCycle(); expectOut("grp3_sum", 48'd6);
        idleCycle(); expectIdle("grp3_c8");

        // Mode 00 beat aborts an open group; next group latches taps on its first beat
        applyStimulus(1'b1, 2'b10, 8'd3, 1, 0, 1, 48'd0, 1'b0, 1'b0); expectIdle("abort_c0");
        applyStimulus(1'b1, 2'b10, 8'd3, 1, 0, 1, 48'd0, 1'b0, 1'b0); expectIdle("abort_c1");
        applyStimulus(1'b1, 2'b00, 8'd0, 5, 0, 1, 48'd0, 1'b0, 1'b0); expectIdle("abort_c2");
        applyStimulus(1'b1, 2'b10, 8'd2, 1, 0, 2, 48'd0, 1'b0, 1'b0); expectIdle("abort_c3");
        applyStimulus(1'b1, 2'b10, 8'd7, 1, 0, 4, 48'd0, 1'b0, 1'b0); expectIdle("abort_c4");
        idleCycle(); expectOut("abort_m00", 48'd5);
        idleCycle(); expectIdle("abort_c6");
        idleCycle(); expectOut("abort_newgrp", 48'd6);
        idleCycle(); expectIdle("abort_c8");

        // Switching from mode 10 to 11 restarts the group with a cascade seed
        applyStimulus(1'b1, 2'b10, 8'd2, 1, 0, 1, 48'd20, 1'b0, 1'b0); expectIdle("swap_c0");
        applyStimulus(1'b1, 2'b11, 8'd2, 1, 0, 1, 48'd20, 1'b0, 1'b0); expectIdle("swap_c1");
        applyStimulus(1'b1, 2'b11, 8'd2, 1, 0, 1, 48'd20, 1'b0, 1'b0); expectIdle("swap_c2");
        idleCycle(); expectIdle("swap_c3");
        idleCycle(); expectIdle("swap_c4");
        idleCycle(); expectOut("swap_seeded", 48'd22);
        idleCycle(); expectIdle("swap_c6");

        // Flush clears an open group and drops the beat presented with it
        I_pcin = 48'd0;
        applyStimulus(1'b1, 2'b10, 8'd2, 1, 0, 5, 48'd0, 1'b0, 1'b0); expectIdle("clr_c0");
        idleCycle(); expectIdle("clr_c1");
        idleCycle(); expectIdle("clr_c2");
        idleCycle(); expectIdle("clr_c3");
        applyStimulus(1'b1, 2'b00, 8'd0, 9, 0, 1, 48'd0, 1'b1, 1'b0); expectIdle("clr_c4");
        applyStimulus(1'b1, 2'b10, 8'd2, 1, 0, 2, 48'd0, 1'b0, 1'b0); expectIdle("clr_c5");
        applyStimulus(1'b1, 2'b10, 8'd2, 1, 0, 3, 48'd0, 1'b0, 1'b0); expectIdle("clr_c6");
        idleCycle(); expectIdle("clr_c7");
        idleCycle(); expectIdle("clr_c8");
        idleCycle(); expectOut("clr_fresh", 48'd5);
        idleCycle(); expectIdle("clr_c10");

        // Mode 11 with taps 0 emits on every back-to-back beat
        applyStimulus(1'b1, 2'b11, 8'd0, 1, 0, 4, 48'd10, 1'b0, 1'b0); expectIdle("b2b_c0");
        applyStimulus(1'b1, 2'b11, 8'd0, 1, 0, 4, 48'd10, 1'b0, 1'b0); expectIdle("b2b_c1");
        applyStimulus(1'b1, 2'b11, 8'd0, 1, 0, 4, 48'd10, 1'b0, 1'b0); expectIdle("b2b_c2");
        idleCycle(); expectOut("b2b_0", 48'd14);
        idleCycle(); expectOut("b2b_1", 48'd14);
        idleCycle(); expectOut("b2b_2", 48'd14);
        idleCycle(); expectIdle("b2b_c6");

        // Reset in the middle of a group leaves no residue
        I_pcin = 48'd0;
        applyStimulus(1'b1, 2'b10, 8'd4, 1, 0, 1, 48'd0, 1'b0, 1'b0); expectIdle("rst_c0");
        applyStimulus(1'b1, 2'b10, 8'd4, 1, 0, 1, 48'd0, 1'b0, 1'b0); expectIdle("rst_c1");
        applyStimulus(1'b0, 2'b10, 8'd4, 1, 0, 1, 48'd0, 1'b0, 1'b1);
        heldP = '0;
        expectIdle("rst_zero");
        checkLanes("rst_zero", 18'd0, 30'd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 2'b10, 8'd4, 1, 0, 1, 48'd0, 1'b0, 1'b0);
            expectIdle("rst_grp_beat");
        end
        idleCycle(); expectIdle("rst_c7");
        idleCycle(); expectIdle("rst_c8");
        idleCycle(); expectOut("rst_fresh_sum", 48'd4);
        idleCycle(); expectIdle("rst_c10");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_unit_acc.md
DSP_UNIT_ACC -- requirements
Module: dsp_unit_acc

Interface
REQ-001 SHALL have parameter WL_W, default 8: signed width of I_weight_l.
REQ-002 SHALL have parameter WH_W, default 8: signed width of I_weight_h.
REQ-003 SHALL have parameter F_W, default 8: signed width of I_feature.
REQ-004 SHALL have parameter SPLIT, default 18: bit position of the high weight lane in the packed product.
REQ-005 SHALL have parameter ACC_W, default 48: width of the product, accumulator and cascade.
REQ-006 SHALL have port I_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port I_rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port I_valid, input, 1 bit: a beat is accepted this cycle; there is no backpressure.
REQ-009 SHALL have port I_mode, input, 2 bits, sampled per beat: 00 product, 01 product+cascade, 10 accumulate, 11 accumulate with cascade seed.
REQ-010 SHALL have port I_taps, input, 8 bits: beats per accumulation group; 0 is treated as 1.
REQ-011 SHALL have port I_weight_l, input, WL_W bits, signed: low-lane weight.
REQ-012 SHALL have port I_weight_h, input, WH_W bits, signed: high-lane weight.
REQ-013 SHALL have port I_feature, input, F_W bits, signed: shared multiplicand.
REQ-014 SHALL have port I_pcin, input, ACC_W bits: cascade input from the upstream unit.
REQ-015 SHALL have port I_clr, input, 1 bit: synchronous flush of the pipeline and accumulator.
REQ-016 SHALL have port O_valid, output, 1 bit: result strobe.
REQ-017 SHALL have port O_last, output, 1 bit: the result closes an accumulation group.
REQ-018 SHALL have port O_p, output, ACC_W bits: the result.
REQ-019 SHALL have port O_pcout, output, ACC_W bits: cascade output, equal to O_p.
REQ-020 SHALL have port O_lo, output, SPLIT bits, signed: unpacked low lane.
REQ-021 SHALL have port O_hi, output, ACC_W-SPLIT bits, signed: unpacked high lane.

Function
REQ-022 Pipeline SHALL be: input regs stage 1 (t+1), input regs stage 2 (t+2), M reg (t+3), P reg (t+4); mode, taps and valid travel with the data.
REQ-023 Pre-add SHALL be AD = (sign-extended I_weight_h << SPLIT) + sign-extended I_weight_l; M = AD * I_feature, signed, sign-extended to ACC_W.
REQ-024 All adds SHALL wrap modulo 2^ACC_W, two's complement, with no saturation.
REQ-025 Mode 00: P = M; O_valid=1 and O_last=1 at t+4.
REQ-026 Mode 01: P = M + I_pcin, with I_pcin sampled at cycle t+3; O_valid=1 and O_last=1 at t+4.
REQ-027 Modes 10/11: a tap counter tap_cnt (0..I_taps-1) SHALL count beats reaching the P stage; I_taps SHALL be latched on the beat with tap_cnt=0.
REQ-028 First beat of a group (tap_cnt=0): acc = M in mode 10, or M + I_pcin in mode 11; later beats: acc = acc + M, with I_pcin ignored.
REQ-029 When tap_cnt = latched taps-1: O_p=acc, O_valid=1 and O_last=1 at t+4, and tap_cnt returns to 0; intermediate beats SHALL NOT assert O_valid.
REQ-030 Gaps in I_valid SHALL be allowed inside a group; only valid beats are counted.
REQ-031 A mode 00/01 beat, or a change between modes 10 and 11, reaching the P stage with tap_cnt≠0 SHALL abort the open group: the partial sum is discarded, tap_cnt=0, and the beat is processed per its own mode.
REQ-032 O_p, O_lo and O_hi SHALL hold their last value between O_valid pulses; O_valid and O_last are single-cycle.
REQ-033 Unpacking SHALL be: O_lo = P[SPLIT-1:0] as signed; O_hi = P[ACC_W-1:SPLIT] + P[SPLIT-1], a sign correction for a negative low lane.
REQ-034 I_clr SHALL zero the valid bits of all stages, tap_cnt and acc on the next edge; an I_valid beat in the same cycle as I_clr SHALL be dropped.

Reset
REQ-035 I_rst SHALL zero every register next edge: O_valid=0, O_last=0, O_p=0, O_pcout=0, O_lo=0, O_hi=0, tap_cnt=0, acc=0, and in-flight beats are discarded.
REQ-036 I_rst SHALL have priority over I_clr and I_valid; the first beat is accepted on the cycle after I_rst deasserts.

Verification
REQ-037 Mode 00 beat with wl=3, wh=-2, f=5 -> at t+4: O_p=-2621425, O_lo=15, O_hi=-10, O_valid=O_last=1.
REQ-038 Mode 00 beat with wl=-3, wh=2, f=5 -> O_lo=-15, O_hi=10.
REQ-039 Mode 01 beat with wl=2, wh=0, f=3 and I_pcin=100 at t+3 -> O_p=106.
REQ-040 Mode 10, taps=3, wl=1, wh=0, f=1,2,3 with a 2-cycle gap after the second beat -> a single O_valid 4 cycles after the third beat, O_p=6, O_last=1.
REQ-041 Mode 11, taps=0 (treated as 1), wl=1, f=4, I_pcin=10 -> O_p=14 on every beat.
REQ-042 Mode 10, taps=4: assert I_rst after 2 beats -> outputs 0; 4 fresh beats of value 1 -> O_p=4, with no leftover contribution from before reset.
